// File: rtl/vgaram_map_writer.sv
// Write-side master for the display tile RAM: fills the level pattern after reset/clear,
// then performs read-modify-write digs on single tiles and reports gem collection.
module vgaram_map_writer #(
  parameter logic [3:0]  TOP_TILE    = 4'h0,
  parameter logic [3:0]  DIRT_TILE   = 4'h1,
  parameter logic [3:0]  TUNNEL_TILE = 4'h2,
  parameter logic [3:0]  GEM_TILE    = 4'h3,
  parameter int unsigned TILE_SHIFT  = 6
) (
  input  logic       clk100m,
  input  logic       reset,
  input  logic       clear_map,
  input  logic       dig_req,
  input  logic [9:0] dig_posx,
  input  logic [9:0] dig_posy,
  output logic       dig_ack,
  output logic       gem_pulse,
  output logic       busy,
  output logic       init_done,
  output logic       vgaram_we,
  output logic [7:0] vgaram_addra,
  output logic [3:0] vgaram_dina,
  input  logic [3:0] vgaram_douta
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_WAIT,
    S_RD_DATA,
    S_ACK
  } state_t;

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       we_q;
  logic [7:0] addr_q;
  logic [3:0] dina_q;
  logic       ack_q;
  logic       gem_q;
  logic       busy_q;
  logic       done_q;

  logic [3:0] pat_d;
  logic [7:0] idx_d;

  function automatic logic [3:0] init_pattern(input logic [7:0] a);
    if (a[7:4] == 4'd0) return TOP_TILE;
    if ((a[7:4] >= 4'd2) && (a[5:4] == 2'b11) && (a[1:0] == 2'b10)) return GEM_TILE;
    return DIRT_TILE;
  endfunction

  always_comb begin
    pat_d = init_pattern(cnt_q);
    idx_d = {dig_posy[TILE_SHIFT+3 -: 4], dig_posx[TILE_SHIFT+3 -: 4]};
  end

  always_ff @(posedge clk100m) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dina_q  <= '0;
      ack_q   <= 1'b0;
      gem_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      we_q  <= 1'b0;
      ack_q <= 1'b0;
      gem_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          we_q   <= 1'b1;
          addr_q <= cnt_q;
          dina_q <= pat_d;
          cnt_q  <= cnt_q + 8'd1;
          done_q <= 1'b0;
          busy_q <= (cnt_q != 8'hFF);
          if (cnt_q == 8'hFF) state_q <= S_IDLE;
        end
        S_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (clear_map) begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_INIT;
          // dig_ack is visible during the first IDLE cycle while the requester still
          // holds dig_req; skipping that cycle prevents re-accepting the same request.
          end else if (dig_req && !ack_q) begin
            addr_q  <= idx_d;
            busy_q  <= 1'b1;
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: state_q <= S_RD_DATA;
        S_RD_DATA: begin
          if ((vgaram_douta == DIRT_TILE) || (vgaram_douta == GEM_TILE)) begin
            we_q   <= 1'b1;
            dina_q <= TUNNEL_TILE;
            gem_q  <= (vgaram_douta == GEM_TILE);
          end
          state_q <= S_ACK;
        end
        S_ACK: begin
          ack_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign dig_ack      = ack_q;
  assign gem_pulse    = gem_q;
  assign busy         = busy_q;
  assign init_done    = done_q;
  assign vgaram_we    = we_q;
  assign vgaram_addra = addr_q;
  assign vgaram_dina  = dina_q;

endmodule

// File: tb/tb_vgaram_map_writer.sv
// Directed bench for vgaram_map_writer with a behavioural one-cycle synchronous tile RAM.
module tb_vgaram_map_writer;

  logic       clk = 1'b0;
  logic       reset, clear_map, dig_req;
  logic [9:0] dig_posx, dig_posy;
  logic       dig_ack, gem_pulse, busy, init_done, vgaram_we;
  logic [7:0] vgaram_addra;
  logic [3:0] vgaram_dina, vgaram_douta;
  logic [3:0] mem [256];

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    bit         disturb;
    int         exp_wr;
    int         exp_addr;
    int         exp_gem;
    int         exp_after;
  } dig_vec_t;

  dig_vec_t vec [6];

  always #5 clk = ~clk;

  vgaram_map_writer #(
    .TOP_TILE(4'h0), .DIRT_TILE(4'h1), .TUNNEL_TILE(4'h2), .GEM_TILE(4'h3), .TILE_SHIFT(6)
  ) dut (
    .clk100m(clk), .reset(reset), .clear_map(clear_map), .dig_req(dig_req),
    .dig_posx(dig_posx), .dig_posy(dig_posy), .dig_ack(dig_ack), .gem_pulse(gem_pulse),
    .busy(busy), .init_done(init_done), .vgaram_we(vgaram_we), .vgaram_addra(vgaram_addra),
    .vgaram_dina(vgaram_dina), .vgaram_douta(vgaram_douta)
  );

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 4'hF;
    vgaram_douta = 4'hF;
  end

  always @(posedge clk) begin
    if (vgaram_we) mem[vgaram_addra] <= vgaram_dina;
    vgaram_douta <= mem[vgaram_addra];
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int pat(input int a);
    int row, col;
    row = a / 16;
    col = a % 16;
    if (row == 0) return 0;
    if (row >= 2 && row % 4 == 3 && col % 4 == 2) return 3;
    return 1;
  endfunction

  task automatic init_check(input string tag);
    int idx = 0, err = 0, early_done = 0, stray = 0, cyc = 0;
    bit started = 0;
    while (idx < 256 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (dig_ack || gem_pulse) stray++;
      if (init_done) early_done++;
      if (vgaram_we) begin
        started = 1;
        if (vgaram_addra != idx[7:0] || int'(vgaram_dina) != pat(idx)) err++;
        idx++;
      end else if (started) begin
        err++;
      end
    end
    check({tag, " init write count"}, idx, 256);
    check({tag, " init addr/data/gaps"}, err, 0);
    check({tag, " init_done low during init"}, early_done, 0);
    check({tag, " no ack/gem during init"}, stray, 0);
    @(posedge clk); #1;
    check({tag, " init_done after init"}, int'(init_done), 1);
    check({tag, " busy after init"}, int'(busy), 0);
    check({tag, " we after init"}, int'(vgaram_we), 0);
  endtask

  task automatic do_dig(input logic [9:0] x, input logic [9:0] y, input bit disturb,
                        output int ack_cyc, output int nwr, output int ngem, output int nack,
                        output int wa, output int wd);
    ack_cyc = -1; nwr = 0; ngem = 0; nack = 0; wa = -1; wd = -1;
    @(negedge clk);
    dig_req  = 1'b1;
    dig_posx = x;
    dig_posy = y;
    @(posedge clk); #1;
    dig_posx = ~x;
    dig_posy = ~y;
    if (disturb) clear_map = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (ack_cyc > 0 && ack_cyc == c - 1) dig_req = 1'b0;
      if (disturb && c == 1) begin clear_map = 1'b1; dig_req = 1'b0; end
      if (disturb && c == 2) begin clear_map = 1'b0; dig_req = 1'b1; end
      if (vgaram_we) begin nwr++; wa = int'(vgaram_addra); wd = int'(vgaram_dina); end
      if (gem_pulse) ngem += vgaram_we ? 1 : 100;
      if (dig_ack) begin nack++; if (ack_cyc < 0) ack_cyc = c; end
    end
    dig_req   = 1'b0;
    clear_map = 1'b0;
  endtask

  initial begin
    int ack_cyc, nwr, ngem, nack, wa, wd, w;

    vec[0] = '{x: 10'd130,  y: 10'd195,  disturb: 0, exp_wr: 1, exp_addr: 'h32, exp_gem: 1, exp_after: 2};
    vec[1] = '{x: 10'd130,  y: 10'd195,  disturb: 1, exp_wr: 0, exp_addr: 'h32, exp_gem: 0, exp_after: 2};
    vec[2] = '{x: 10'd70,   y: 10'd70,   disturb: 0, exp_wr: 1, exp_addr: 'h11, exp_gem: 0, exp_after: 2};
    vec[3] = '{x: 10'd320,  y: 10'd10,   disturb: 0, exp_wr: 0, exp_addr: 'h05, exp_gem: 0, exp_after: 0};
    vec[4] = '{x: 10'd1023, y: 10'd1023, disturb: 1, exp_wr: 1, exp_addr: 'hFF, exp_gem: 0, exp_after: 2};
    vec[5] = '{x: 10'd133,  y: 10'd448,  disturb: 0, exp_wr: 1, exp_addr: 'h72, exp_gem: 1, exp_after: 2};

    reset = 1'b1; clear_map = 1'b0; dig_req = 1'b0; dig_posx = '0; dig_posy = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset we", int'(vgaram_we), 0);
    check("reset addra", int'(vgaram_addra), 0);
    check("reset dina", int'(vgaram_dina), 0);
    check("reset dig_ack", int'(dig_ack), 0);
    check("reset gem_pulse", int'(gem_pulse), 0);
    check("reset busy", int'(busy), 1);
    check("reset init_done", int'(init_done), 0);
    @(negedge clk);
    reset = 1'b0;
    init_check("boot");
    check("ram 0x00", int'(mem[8'h00]), 0);
    check("ram 0x10", int'(mem[8'h10]), 1);
    check("ram 0x32", int'(mem[8'h32]), 3);
    check("ram 0x33", int'(mem[8'h33]), 1);
    check("ram 0x72", int'(mem[8'h72]), 3);

    for (int i = 0; i < 6; i++) begin
      do_dig(vec[i].x, vec[i].y, vec[i].disturb, ack_cyc, nwr, ngem, nack, wa, wd);
      check($sformatf("dig%0d ack latency", i), ack_cyc, 3);
      check($sformatf("dig%0d ack count", i), nack, 1);
      check($sformatf("dig%0d write count", i), nwr, vec[i].exp_wr);
      check($sformatf("dig%0d gem count", i), ngem, vec[i].exp_gem);
      if (vec[i].exp_wr != 0) begin
        check($sformatf("dig%0d write addr", i), wa, vec[i].exp_addr);
        check($sformatf("dig%0d write data", i), wd, 2);
      end
      check($sformatf("dig%0d ram after", i), int'(mem[vec[i].exp_addr[7:0]]), vec[i].exp_after);
    end

    // clear_map wins over a simultaneous dig_req in IDLE
    @(negedge clk);
    clear_map = 1'b1; dig_req = 1'b1; dig_posx = 10'd70; dig_posy = 10'd70;
    @(posedge clk); #1;
    check("clear busy", int'(busy), 1);
    check("clear init_done low", int'(init_done), 0);
    clear_map = 1'b0; dig_req = 1'b0;
    init_check("clear");
    check("clear restores 0x11", int'(mem[8'h11]), 1);
    check("clear restores 0x32", int'(mem[8'h32]), 3);

    // reset while the dig is in RD_WAIT
    @(negedge clk);
    dig_req = 1'b1; dig_posx = 10'd130; dig_posy = 10'd195;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rdwait reset busy", int'(busy), 1);
    check("rdwait reset we", int'(vgaram_we), 0);
    @(negedge clk);
    reset = 1'b0; dig_req = 1'b0;
    init_check("rdwait reset");
    check("rdwait reset gem intact", int'(mem[8'h32]), 3);

    // reset at INIT cell 100
    @(negedge clk);
    clear_map = 1'b1;
    @(posedge clk); #1;
    clear_map = 1'b0;
    w = 0;
    while (!(vgaram_we && vgaram_addra == 8'd100) && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    check("reached init cell 100", int'(w < 400), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("cell100 reset we", int'(vgaram_we), 0);
    check("cell100 reset init_done", int'(init_done), 0);
    @(negedge clk);
    reset = 1'b0;
    init_check("cell100 reset");

    do_dig(vec[0].x, vec[0].y, 1'b0, ack_cyc, nwr, ngem, nack, wa, wd);
    check("final dig ack latency", ack_cyc, 3);
    check("final dig write", nwr, 1);
    check("final dig gem", ngem, 1);
    check("final dig addr", wa, 'h32);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
